fdiv: RTL and testbench



---
 rtl/fdiv.sv | 196 +++++++++++++++++++
 tb/tb_fdiv.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv.sv
// MIX FPU floating-point divide (command 4): bit-serial restoring divide of
// two 31-bit MIX words, then normalization and round-to-nearest-even.
module fdiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [30:0] in1,
  input  logic [30:0] in2,
  output logic [30:0] out,
  output logic        stop,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned WW  = 31;  // packed word width
  localparam int unsigned FW  = 24;  // fraction width
  localparam int unsigned XW  = 6;   // exponent field width
  localparam int unsigned EW  = 8;   // working exponent width (two's complement)
  localparam int unsigned QW  = 36;  // quotient width
  localparam int unsigned RW  = 26;  // partial remainder width
  localparam int unsigned CW  = 6;   // iteration counter width
  localparam int unsigned LW  = QW - XW;  // zero bits appended below the dividend

  localparam logic [EW-1:0] EXP_ADJ  = EW'(33);
  localparam logic [FW-1:0] ONE_FRAC = FW'(24'h040000);
  localparam logic [CW-1:0] LAST_IT  = CW'(QW - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIV,
    DONE
  } state_t;

  state_t        state;
  logic          sgn;
  logic [XW-1:0] eu;
  logic [FW-1:0] fu;
  logic [FW-1:0] fv;
  logic [EW-1:0] e;
  logic [QW-1:0] q;
  logic [QW-1:0] dvd;
  logic [RW-1:0] rem;
  logic [CW-1:0] cnt;

  // One restoring-division step: bring down the next dividend bit and subtract.
  logic [RW-1:0] r_sh;
  logic [RW-1:0] rem_nx;
  logic          q_bit;
  logic [QW-1:0] q_nx;

  always_comb begin
    r_sh   = {rem[RW-2:0], dvd[QW-1]};
    q_bit  = (r_sh >= RW'(fv));
    rem_nx = q_bit ? (r_sh - RW'(fv)) : r_sh;
    q_nx   = {q[QW-2:0], q_bit};
  end

  // Normalize, round and pack the final quotient of the last step.
  logic [FW-1:0] m;
  logic          g_msb;
  logic          g_rest;
  logic          inc;
  logic [FW:0]   m_sum;
  logic [FW-1:0] m_fin;
  logic [EW-1:0] e_n;
  logic [EW-1:0] e_fin;
  logic          e_bad;
  logic [WW-1:0] res_out;
  logic          res_ovf;

  always_comb begin
    m       = '0;
    g_msb   = 1'b0;
    g_rest  = 1'b0;
    e_n     = e;
    inc     = 1'b0;
    m_sum   = '0;
    m_fin   = '0;
    e_fin   = e;
    e_bad   = 1'b0;
    res_out = '0;
    res_ovf = 1'b0;

    if (q_nx[QW-1:QW-XW] != '0) begin
      m      = q_nx[QW-1:QW-FW];
      g_msb  = q_nx[QW-FW-1];
      g_rest = (q_nx[QW-FW-2:0] != '0);
    end else begin
      m      = q_nx[QW-XW-1:XW];
      g_msb  = q_nx[XW-1];
      g_rest = (q_nx[XW-2:0] != '0);
      e_n    = e - EW'(1);
    end

    inc   = g_msb & (g_rest | (rem_nx != '0) | m[0]);
    m_sum = {1'b0, m} + (FW+1)'(inc);

    if (m_sum[FW]) begin
      m_fin = ONE_FRAC;
      e_fin = e_n + EW'(1);
    end else begin
      m_fin = m_sum[FW-1:0];
      e_fin = e_n;
    end

    // Out of 0..63 shows up as a set bit above the 6-bit field.
    e_bad = e_fin[EW-1] | e_fin[EW-2];

    if (fv == '0) begin
      res_out = '0;
      res_ovf = 1'b1;
    end else if (fu == '0) begin
      res_out = {sgn, (WW-1)'(0)};
      res_ovf = 1'b0;
    end else begin
      res_out = {sgn, e_fin[XW-1:0], m_fin};
      res_ovf = e_bad;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sgn      <= 1'b0;
      eu       <= '0;
      fu       <= '0;
      fv       <= '0;
      e        <= '0;
      q        <= '0;
      dvd      <= '0;
      rem      <= '0;
      cnt      <= '0;
      out      <= '0;
      stop     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sgn   <= in1[WW-1];
            eu    <= in1[WW-2:FW];
            fu    <= in1[FW-1:0];
            busy  <= 1'b1;
            state <= LOAD;
          end
        end

        LOAD: begin
          sgn   <= sgn ^ in2[WW-1];
          e     <= EW'(eu) - EW'(in2[WW-2:FW]) + EXP_ADJ;
          fv    <= in2[FW-1:0];
          rem   <= RW'(fu[FW-1:XW]);
          dvd   <= {fu[XW-1:0], LW'(0)};
          q     <= '0;
          cnt   <= '0;
          state <= DIV;
        end

        DIV: begin
          rem <= rem_nx;
          q   <= q_nx;
          dvd <= {dvd[QW-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (cnt == LAST_IT) begin
            out      <= res_out;
            overflow <= res_ovf;
            stop     <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          out      <= '0;
          overflow <= 1'b0;
          stop     <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
          // The done cycle already counts as idle for a new request.
          if (start) begin
            sgn   <= in1[WW-1];
            eu    <= in1[WW-2:FW];
            fu    <= in1[FW-1:0];
            busy  <= 1'b1;
            state <= LOAD;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv.sv
// Self-checking bench for fdiv: directed cases from the MIX examples, control
// scenarios, and random normalized operands against an integer reference model.
module tb_fdiv;

  logic        clk;
  logic        reset;
  logic        start;
  logic [30:0] in1;
  logic [30:0] in2;
  logic [30:0] out;
  logic        stop;
  logic        busy;
  logic        overflow;

  int errors;
  int checks;

  typedef struct {
    logic [30:0] out;
    logic        ovf;
    string       name;
  } exp_t;

  exp_t sb[$];

  fdiv dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in1      (in1),
    .in2      (in2),
    .out      (out),
    .stop     (stop),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference quotient computed with wide integer division.
  function automatic logic [31:0] model(input logic [30:0] a, input logic [30:0] b);
    longint unsigned n, qq, rr, mm;
    int              ee;
    logic            s, gm, grest, incr;
    logic [5:0]      e6;
    s = a[30] ^ b[30];
    if (b[23:0] == 24'd0) return 32'h8000_0000;
    if (a[23:0] == 24'd0) return {1'b0, s, 30'd0};
    ee = int'(a[29:24]) - int'(b[29:24]) + 33;
    n  = 64'(a[23:0]) << 30;
    qq = n / 64'(b[23:0]);
    rr = n % 64'(b[23:0]);
    if ((qq >> 30) != 0) begin
      mm    = (qq >> 12) & 64'hFF_FFFF;
      gm    = qq[11];
      grest = (qq & 64'h7FF) != 0;
    end else begin
      mm    = (qq >> 6) & 64'hFF_FFFF;
      gm    = qq[5];
      grest = (qq & 64'h1F) != 0;
      ee    = ee - 1;
    end
    incr = gm && (grest || rr != 0 || mm[0]);
    mm   = mm + 64'(incr);
    if (mm == 64'h100_0000) begin
      mm = 64'h04_0000;
      ee = ee + 1;
    end
    e6 = ee[5:0];
    return {(ee < 0 || ee > 63), s, e6, mm[23:0]};
  endfunction

  // Drives one operation starting in the current cycle (S) and checks it;
  // returns positioned in cycle S+39 so the caller may start again at once.
  task automatic run_op(input logic [30:0] a, input logic [30:0] b,
                        input logic [30:0] exp_out, input logic exp_ovf,
                        input string name, input bit extra_start);
    exp_t e;
    int   lat;
    bit   seen;
    sb.push_back('{out: exp_out, ovf: exp_ovf, name: name});
    start = 1'b1;
    in1   = a;
    in2   = 31'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    in1   = 31'($urandom);
    in2   = b;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_s1: got %b want 1", name, busy);
    end
    seen = 1'b0;
    lat  = 0;
    for (int k = 2; k <= 60 && !seen; k++) begin
      @(posedge clk); #1;
      in2   = 31'($urandom);
      start = extra_start && (k == 5);
      if (k == 5) in1 = 31'h3F0C_0000;
      if (stop === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no stop within 60 cycles, want stop at 38", e.name);
    end else begin
      if (lat != 38) begin
        errors++;
        $display("FAIL %s latency: got %0d want 38", e.name, lat);
      end
      checks++;
      if (out !== e.out) begin
        errors++;
        $display("FAIL %s out: got %h want %h", e.name, out, e.out);
      end
      checks++;
      if (overflow !== e.ovf) begin
        errors++;
        $display("FAIL %s overflow: got %b want %b", e.name, overflow, e.ovf);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_done: got %b want 1", e.name, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (stop !== 1'b0 || out !== 31'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s after_done: stop=%b out=%h ovf=%b busy=%b want 0/0/0/0",
                 e.name, stop, out, overflow, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stop !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || out !== 31'd0) begin
      errors++;
      $display("FAIL reset_state: stop=%b busy=%b ovf=%b out=%h want all 0",
               stop, busy, overflow, out);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_op(31'h2104_0000, 31'h2104_0000, 31'h2104_0000, 1'b0, "one_div_one", 1'b0);
    run_op(31'h2104_0000, 31'h210C_0000, 31'h2055_5555, 1'b0, "one_div_three", 1'b0);
    run_op(31'h2108_0000, 31'h210C_0000, 31'h20AA_AAAB, 1'b0, "two_div_three", 1'b0);
  endtask

  task automatic test_sign();
    run_op(31'h6104_0000, 31'h2104_0000, 31'h6104_0000, 1'b0, "neg_div_pos", 1'b0);
    run_op(31'h6104_0000, 31'h6104_0000, 31'h2104_0000, 1'b0, "neg_div_neg", 1'b0);
  endtask

  task automatic test_range();
    run_op(31'h3F04_0000, 31'h0004_0000, 31'h2004_0000, 1'b1, "exp_high", 1'b0);
    run_op(31'h0004_0000, 31'h3F04_0000, 31'h2204_0000, 1'b1, "exp_low", 1'b0);
    run_op(31'h3F04_0000, 31'h2104_0000, 31'h3F04_0000, 1'b0, "exp_max_ok", 1'b0);
    run_op(31'h0004_0000, 31'h210C_0000, 31'h3F55_5555, 1'b1, "exp_norm_under", 1'b0);
  endtask

  task automatic test_zero();
    run_op(31'h2104_0000, 31'h2100_0000, 31'h0000_0000, 1'b1, "div_by_zero", 1'b0);
    run_op(31'h0000_0000, 31'h2104_0000, 31'h0000_0000, 1'b0, "zero_dividend", 1'b0);
    run_op(31'h4000_0000, 31'h2104_0000, 31'h4000_0000, 1'b0, "neg_zero_dividend", 1'b0);
  endtask

  task automatic test_abort();
    bit stray;
    start = 1'b1;
    in1   = 31'h2104_0000;
    @(posedge clk); #1;
    start = 1'b0;
    in2   = 31'h210C_0000;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b want 0", busy);
    end
    stray = 1'b0;
    for (int k = 0; k < 45; k++) begin
      if (stop === 1'b1) stray = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL abort_stop: got stop=1 after reset want none");
    end
    run_op(31'h2108_0000, 31'h210C_0000, 31'h20AA_AAAB, 1'b0, "after_abort", 1'b0);
  endtask

  task automatic test_reset_with_start();
    reset = 1'b1;
    start = 1'b1;
    in1   = 31'h2104_0000;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_ignored_start();
    run_op(31'h2108_0000, 31'h210C_0000, 31'h20AA_AAAB, 1'b0, "ignored_start", 1'b1);
  endtask

  task automatic test_back_to_back();
    run_op(31'h2104_0000, 31'h210C_0000, 31'h2055_5555, 1'b0, "b2b_first", 1'b0);
    run_op(31'h6108_0000, 31'h210C_0000, 31'h60AA_AAAB, 1'b0, "b2b_second", 1'b0);
  endtask

  task automatic test_random();
    logic [30:0] a, b;
    logic [31:0] r;
    for (int i = 0; i < 16; i++) begin
      a = {1'($urandom), 6'($urandom_range(63, 0)), 24'($urandom_range(24'hFF_FFFF, 24'h04_0000))};
      b = {1'($urandom), 6'($urandom_range(63, 0)), 24'($urandom_range(24'hFF_FFFF, 24'h04_0000))};
      r = model(a, b);
      run_op(a, b, r[30:0], r[31], $sformatf("rand%0d", i), 1'b0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_sign();
    test_range();
    test_zero();
    test_abort();
    test_reset_with_start();
    test_ignored_start();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
